regfile_param: RTL
==================

# regfile_param

Parametrised register bank: DEPTH entries of WIDTH bits with byte-lane write strobes, two independent registered read ports, optional write-to-read bypass and per-entry valid tracking. It generalises the single 8-bit load register to a small addressable storage array. It serves as scratch/config storage for datapath and control blocks.

## Interface
- WIDTH, 8, entry width in bits; multiple of 8, at least 8
- DEPTH, 8, number of entries; at least 2, need not be a power of two
- BYPASS, 1, 1: a read of an address written in the same cycle returns the new data; 0: it returns the old data
- RESET_VAL, 0, WIDTH-bit value loaded into every entry on reset or clear
- AW (localparam) = max(1, $clog2(DEPTH)); NB = WIDTH/8

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- async_rst  in  1  asynchronous, active-high reset
- sync_clr  in  1  synchronous clear of all entries, valid flags and addr_err
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- wr_strb  in  NB  byte-lane enables; bit i gates wr_data[8i+7:8i]
- rd_en_a  in  1  port A read enable
- rd_addr_a  in  AW  port A address
- rd_data_a  out  WIDTH  port A registered read data
- rd_en_b  in  1  port B read enable
- rd_addr_b  in  AW  port B address
- rd_data_b  out  WIDTH  port B registered read data
- entry_valid  out  DEPTH  bit n is set once entry n has had any write since reset or clear
- addr_err  out  1  sticky out-of-range access flag

## Operation
- Reset (async_rst=1, takes effect immediately, no clock needed):
  - every entry = RESET_VAL
  - rd_data_a and rd_data_b = 0
  - entry_valid = 0
  - addr_err = 0
- Write: on a clock edge with wr_en=1, sync_clr=0 and wr_addr<DEPTH:
  - each lane i with wr_strb[i]=1 takes the new byte; other lanes keep their value
  - entry_valid[wr_addr] is set even when wr_strb=0
- Read, per port independently: on a clock edge with rd_en_x=1:
  - rd_data_x = contents of rd_addr_x, sampled before this edge's write
  - BYPASS=1 and a qualifying write to the same address on the same edge: the merged result instead (strobed lanes from wr_data, others from storage)
  - rd_en_x=0: rd_data_x holds
  - Both ports may read the same address in the same cycle.
- Out of range (addr >= DEPTH; possible only when DEPTH is not a power of two):
  - write is dropped and entry_valid is unchanged
  - read loads 0 into rd_data_x
  - any out-of-range write or enabled read sets addr_err, which stays set until reset or sync_clr
- sync_clr on a clock edge:
  - all entries = RESET_VAL; entry_valid = 0; addr_err = 0
  - a simultaneous write is dropped and sets nothing
  - simultaneous reads return the pre-clear contents, with no bypass
  - rd_data_x registers are not cleared
- Priority: async_rst > sync_clr > write. Write and read are concurrent.

## Timing
- Read latency is 1 cycle: address at edge k gives data valid after edge k.
- Write is visible to a non-bypassed read issued on the next edge.
- entry_valid and addr_err are registered and update on the same edge as the triggering access.
- Reset asserted mid-operation clears state immediately. The first write is accepted on the first edge after async_rst deasserts.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert async_rst between edges -> every output 0 at once; read all addresses -> RESET_VAL; entry_valid=0.
- Strobed write: write 0xA5A5 to addr 3 with strb=2'b11, then 0x1234 with strb=2'b01 (WIDTH=16) -> read addr 3 = 0xA534; entry_valid=8'b0000_1000.
- Bypass:
  - BYPASS=1: entry 2 holds 0x11; write 0x22 to addr 2 and read A addr 2 on the same edge -> rd_data_a=0x22.
  - BYPASS=0: same sequence -> rd_data_a=0x11, and the next read gives 0x22.
- Dual port, hold and out-of-range:
  - Read A addr 1 and B addr 1 on one edge -> identical data.
  - rd_en_a=0 -> rd_data_a holds.
  - DEPTH=6: write addr 7 -> dropped, addr_err=1, and a read of addr 7 returns 0.
- Clear collision: sync_clr=1 with wr_en=1 to addr 0 and read A addr 0 -> rd_data_a = old value; then entry 0 = RESET_VAL, entry_valid=0, addr_err=0.

Source files
------------

// File: rtl/regfile_param_if.sv
// ---------------------------------------------------------------------------
// regfile_param_if
// Access bus of the regfile_param register bank.
//   master : the client driving clear, write and read requests
//   slave  : the register bank returning read data and status
// Signals:
//   sync_clr              synchronous clear of entries, valid flags, addr_err
//   wr_en/wr_addr/wr_data/wr_strb   write request with byte-lane strobes
//   rd_en_a/rd_addr_a/rd_data_a     read port A (registered data)
//   rd_en_b/rd_addr_b/rd_data_b     read port B (registered data)
//   entry_valid           per-entry "written since reset/clear" flags
//   addr_err              sticky out-of-range access flag
// ---------------------------------------------------------------------------
interface regfile_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB = WIDTH / 8;

   logic             sync_clr;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [NB-1:0]    wr_strb;
   logic             rd_en_a;
   logic [AW-1:0]    rd_addr_a;
   logic [WIDTH-1:0] rd_data_a;
   logic             rd_en_b;
   logic [AW-1:0]    rd_addr_b;
   logic [WIDTH-1:0] rd_data_b;
   logic [DEPTH-1:0] entry_valid;
   logic             addr_err;

   modport master (
      output sync_clr, wr_en, wr_addr, wr_data, wr_strb,
      output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      input  rd_data_a, rd_data_b, entry_valid, addr_err
   );

   modport slave (
      input  sync_clr, wr_en, wr_addr, wr_data, wr_strb,
      input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
      output rd_data_a, rd_data_b, entry_valid, addr_err
   );
endinterface

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// DEPTH x WIDTH register bank with byte-lane write strobes, two independent
// registered read ports, optional write-to-read bypass, per-entry valid flags
// and a sticky out-of-range access flag.
// Ports:
//   clk        system clock, rising edge
//   async_rst  asynchronous active-high reset
//   bus        regfile_param_if slave modport (requests in, data/status out)
// ---------------------------------------------------------------------------
module regfile_param #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 8,
   parameter bit               BYPASS    = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input logic           clk,
   input logic           async_rst,
   regfile_param_if.slave bus
);
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB   = WIDTH / 8;
   localparam bit FULL = (DEPTH == (1 << AW));

   // Replace strobed byte lanes of old_v with the matching lanes of new_v.
   function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] new_v,
                                                    input logic [NB-1:0]    strb);
      logic [WIDTH-1:0] res;
      res = old_v;
      for (int i = 0; i < NB; i++) begin
         res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] rd_a_q, rd_a_d;
   logic [WIDTH-1:0] rd_b_q, rd_b_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             err_q, err_d;

   logic             wr_in_range_s, rd_a_in_range_s, rd_b_in_range_s;
   logic             wr_ok_s;
   logic [WIDTH-1:0] mem_w_s, mem_a_s, mem_b_s, wr_merged_s;

   // Address range checks only matter when DEPTH leaves unused address codes.
   generate
      if (FULL) begin : g_full
         assign wr_in_range_s   = 1'b1;
         assign rd_a_in_range_s = 1'b1;
         assign rd_b_in_range_s = 1'b1;
      end else begin : g_part
         localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
         assign wr_in_range_s   = ({1'b0, bus.wr_addr}   < DEPTH_C);
         assign rd_a_in_range_s = ({1'b0, bus.rd_addr_a} < DEPTH_C);
         assign rd_b_in_range_s = ({1'b0, bus.rd_addr_b} < DEPTH_C);
      end
   endgenerate

   // A write only lands when in range and not overridden by a clear.
   assign wr_ok_s = bus.wr_en & ~bus.sync_clr & wr_in_range_s;

   // Storage read muxes for the write target and both read ports.
   always_comb begin
      mem_w_s = {WIDTH{1'b0}};
      mem_a_s = {WIDTH{1'b0}};
      mem_b_s = {WIDTH{1'b0}};
      for (int n = 0; n < DEPTH; n++) begin
         mem_w_s = (bus.wr_addr   == AW'(n)) ? mem_q[n] : mem_w_s;
         mem_a_s = (bus.rd_addr_a == AW'(n)) ? mem_q[n] : mem_a_s;
         mem_b_s = (bus.rd_addr_b == AW'(n)) ? mem_q[n] : mem_b_s;
      end
      wr_merged_s = merge_lanes(mem_w_s, bus.wr_data, bus.wr_strb);
   end

   // Next read data: hold when idle, zero when out of range, merged on bypass.
   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (!bus.rd_en_a) begin
         rd_a_d = rd_a_q;
      end else if (!rd_a_in_range_s) begin
         rd_a_d = {WIDTH{1'b0}};
      end else if (BYPASS && wr_ok_s && (bus.wr_addr == bus.rd_addr_a)) begin
         rd_a_d = wr_merged_s;
      end else begin
         rd_a_d = mem_a_s;
      end
      if (!bus.rd_en_b) begin
         rd_b_d = rd_b_q;
      end else if (!rd_b_in_range_s) begin
         rd_b_d = {WIDTH{1'b0}};
      end else if (BYPASS && wr_ok_s && (bus.wr_addr == bus.rd_addr_b)) begin
         rd_b_d = wr_merged_s;
      end else begin
         rd_b_d = mem_b_s;
      end
   end

   // Next storage, valid flags and sticky error; clear outranks any write.
   always_comb begin
      for (int n = 0; n < DEPTH; n++) begin
         mem_d[n]   = mem_q[n];
         valid_d[n] = valid_q[n];
         if (bus.sync_clr) begin
            mem_d[n]   = RESET_VAL;
            valid_d[n] = 1'b0;
         end else if (wr_ok_s && (bus.wr_addr == AW'(n))) begin
            mem_d[n]   = wr_merged_s;
            valid_d[n] = 1'b1;
         end else begin
            mem_d[n]   = mem_q[n];
            valid_d[n] = valid_q[n];
         end
      end
      if (bus.sync_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q
               | (bus.wr_en   & ~wr_in_range_s)
               | (bus.rd_en_a & ~rd_a_in_range_s)
               | (bus.rd_en_b & ~rd_b_in_range_s);
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         for (int n = 0; n < DEPTH; n++) begin
            mem_q[n] <= RESET_VAL;
         end
         rd_a_q  <= {WIDTH{1'b0}};
         rd_b_q  <= {WIDTH{1'b0}};
         valid_q <= {DEPTH{1'b0}};
         err_q   <= 1'b0;
      end else begin
         for (int n = 0; n < DEPTH; n++) begin
            mem_q[n] <= mem_d[n];
         end
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign bus.rd_data_a   = rd_a_q;
   assign bus.rd_data_b   = rd_b_q;
   assign bus.entry_valid = valid_q;
   assign bus.addr_err    = err_q;
endmodule
